stash_op_rr_arbiter: RTL and testbench

Packet-granular round-robin arbiter that drains NUM_IN stash input FIFOs, one per operand ingress block, onto a single AXI4-Stream master toward the stash/aggregation core. Each requester is a first-word-fall-through packet FIFO exposing empty, rd_en and dout (tdata/tuser/tkeep/tlast). A grant is held for a whole packet, from first word through tlast, so packets from different ports never interleave.

---
 rtl/stash_op_rr_arbiter.sv | 121 ++++++++++++
 tb/tb_stash_op_rr_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stash_op_rr_arbiter.sv
// Packet-granular round-robin merge of NUM_IN FWFT packet FIFOs onto one AXI4-Stream master.
// One-cycle arbitration bubble per packet; tready stalls pop only, the grant is held until tlast.
module stash_op_rr_arbiter #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_IN               = 4,
  parameter int GRANT_W              = $clog2(NUM_IN)
) (
  input  logic                                   axis_aclk,
  input  logic                                   axis_resetn,
  input  logic [NUM_IN-1:0]                      i_pkt_fifo_empty,
  output logic [NUM_IN-1:0]                      o_pkt_fifo_rd_en,
  input  logic [NUM_IN*C_S_AXIS_DATA_WIDTH-1:0]  i_tdata_fifo,
  input  logic [NUM_IN*C_S_AXIS_TUSER_WIDTH-1:0] i_tuser_fifo,
  input  logic [NUM_IN*C_S_AXIS_DATA_WIDTH/8-1:0] i_tkeep_fifo,
  input  logic [NUM_IN-1:0]                      i_tlast_fifo,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]        m_axis_tuser,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]       m_axis_tkeep,
  output logic                                   m_axis_tlast,
  output logic                                   m_axis_tvalid,
  input  logic                                   m_axis_tready,
  output logic [GRANT_W-1:0]                     o_grant,
  output logic                                   o_busy,
  output logic [31:0]                            o_pkt_cnt
);

  localparam int DW = C_S_AXIS_DATA_WIDTH;
  localparam int UW = C_S_AXIS_TUSER_WIDTH;
  localparam int KW = C_S_AXIS_DATA_WIDTH / 8;

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state_q, state_d;
  logic [GRANT_W-1:0] grant_q, grant_d;
  logic [GRANT_W-1:0] last_grant_q, last_grant_d;
  logic [GRANT_W-1:0] sel;
  logic               any_req;
  logic               hs_last;
  logic [31:0]        pkt_cnt_q;

  logic [DW-1:0] tdata_arr [NUM_IN];
  logic [UW-1:0] tuser_arr [NUM_IN];
  logic [KW-1:0] tkeep_arr [NUM_IN];

  for (genvar k = 0; k < NUM_IN; k++) begin : g_unflatten
    assign tdata_arr[k] = i_tdata_fifo[k*DW +: DW];
    assign tuser_arr[k] = i_tuser_fifo[k*UW +: UW];
    assign tkeep_arr[k] = i_tkeep_fifo[k*KW +: KW];
  end

  // Scan from the farthest offset down so the nearest port after last_grant wins.
  always_comb begin
    logic [GRANT_W-1:0] idx;
    any_req = 1'b0;
    sel     = '0;
    idx     = '0;
    for (int i = NUM_IN; i >= 1; i--) begin
      idx = GRANT_W'((int'(last_grant_q) + i) % NUM_IN);
      if (!i_pkt_fifo_empty[idx]) begin
        any_req = 1'b1;
        sel     = idx;
      end
    end
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GRANT_W'(NUM_IN - 1);
      pkt_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      if (hs_last) pkt_cnt_q <= pkt_cnt_q + 32'd1;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: if (any_req) begin
        state_d = SEND;
        grant_d = sel;
      end
      SEND: if (hs_last) begin
        state_d      = IDLE;
        last_grant_d = grant_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // An underflowing granted FIFO just drops tvalid; the grant stays put until tlast.
  always_comb begin
    m_axis_tvalid    = 1'b0;
    m_axis_tdata     = '0;
    m_axis_tuser     = '0;
    m_axis_tkeep     = '0;
    m_axis_tlast     = 1'b0;
    o_pkt_fifo_rd_en = '0;
    if (state_q == SEND) begin
      m_axis_tvalid             = !i_pkt_fifo_empty[grant_q];
      m_axis_tdata              = tdata_arr[grant_q];
      m_axis_tuser              = tuser_arr[grant_q];
      m_axis_tkeep              = tkeep_arr[grant_q];
      m_axis_tlast              = i_tlast_fifo[grant_q];
      o_pkt_fifo_rd_en[grant_q] = m_axis_tvalid & m_axis_tready;
    end
  end

  assign hs_last   = m_axis_tvalid & m_axis_tready & m_axis_tlast;
  assign o_grant   = grant_q;
  assign o_busy    = (state_q == SEND);
  assign o_pkt_cnt = pkt_cnt_q;

endmodule

// File: tb/tb_stash_op_rr_arbiter.sv
// Directed bench for stash_op_rr_arbiter: queue-backed FWFT FIFOs feed the DUT, expected words are built by mk().
module tb_stash_op_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 256;
  localparam int UW = 128;
  localparam int KW = 32;
  localparam int GW = 2;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [UW-1:0] u;
    logic [KW-1:0] k;
    logic          l;
  } word_t;

  logic            clk = 1'b0;
  logic            axis_resetn;
  logic [N-1:0]    fifo_empty;
  logic [N-1:0]    fifo_rd_en;
  logic [N*DW-1:0] tdata_fifo;
  logic [N*UW-1:0] tuser_fifo;
  logic [N*KW-1:0] tkeep_fifo;
  logic [N-1:0]    tlast_fifo;
  logic [DW-1:0]   m_axis_tdata;
  logic [UW-1:0]   m_axis_tuser;
  logic [KW-1:0]   m_axis_tkeep;
  logic            m_axis_tlast;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
  logic [GW-1:0]   o_grant;
  logic            o_busy;
  logic [31:0]     o_pkt_cnt;

  word_t q [N][$];
  int    tests = 0;
  int    fails = 0;

  always #5 clk = ~clk;

  stash_op_rr_arbiter #(
    .C_S_AXIS_DATA_WIDTH (DW),
    .C_S_AXIS_TUSER_WIDTH(UW),
    .NUM_IN              (N),
    .GRANT_W             (GW)
  ) dut (
    .axis_aclk       (clk),
    .axis_resetn     (axis_resetn),
    .i_pkt_fifo_empty(fifo_empty),
    .o_pkt_fifo_rd_en(fifo_rd_en),
    .i_tdata_fifo    (tdata_fifo),
    .i_tuser_fifo    (tuser_fifo),
    .i_tkeep_fifo    (tkeep_fifo),
    .i_tlast_fifo    (tlast_fifo),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tuser    (m_axis_tuser),
    .m_axis_tkeep    (m_axis_tkeep),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready),
    .o_grant         (o_grant),
    .o_busy          (o_busy),
    .o_pkt_cnt       (o_pkt_cnt)
  );

  function automatic word_t mk(int p, int tag, int w, int len);
    word_t e;
    e.d = {8{32'(p * 4096 + tag * 16 + w)}};
    e.u = {4{32'(tag * 256 + p * 16 + w + 7)}};
    e.k = 32'hFFFF_FFFF >> w;
    e.l = (w == len - 1);
    return e;
  endfunction

  task automatic refresh();
    word_t e;
    for (int k = 0; k < N; k++) begin
      fifo_empty[k] = (q[k].size() == 0);
      e = (q[k].size() == 0) ? '0 : q[k][0];
      tdata_fifo[k*DW +: DW] = e.d;
      tuser_fifo[k*UW +: UW] = e.u;
      tkeep_fifo[k*KW +: KW] = e.k;
      tlast_fifo[k]          = e.l;
    end
  endtask

  task automatic push_words(int p, int tag, int w0, int w1, int len);
    for (int w = w0; w <= w1; w++) q[p].push_back(mk(p, tag, w, len));
    refresh();
  endtask

  // Pops are taken from rd_en as seen just before the edge, applied 1 time unit after it.
  task automatic step();
    logic [N-1:0] pm;
    word_t        tmp;
    pm = fifo_rd_en;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++)
      if (pm[k] && q[k].size() > 0) tmp = q[k].pop_front();
    refresh();
  endtask

  task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_word(int p, int tag, int w, int len);
    word_t e;
    e = mk(p, tag, w, len);
    chk("tvalid", DW'(m_axis_tvalid), DW'(1));
    chk("grant", DW'(o_grant), DW'(p));
    chk("busy", DW'(o_busy), DW'(1));
    chk("tdata", m_axis_tdata, e.d);
    chk("tuser", DW'(m_axis_tuser), DW'(e.u));
    chk("tkeep", DW'(m_axis_tkeep), DW'(e.k));
    chk("tlast", DW'(m_axis_tlast), DW'(e.l));
    chk("rd_en", DW'(fifo_rd_en), m_axis_tready ? DW'(1 << p) : DW'(0));
  endtask

  task automatic expect_pkt(int p, int tag, int len);
    m_axis_tready = 1'b1;
    #1;
    chk("bubble_tvalid", DW'(m_axis_tvalid), DW'(0));
    chk("bubble_busy", DW'(o_busy), DW'(0));
    chk("bubble_rd_en", DW'(fifo_rd_en), DW'(0));
    step();
    for (int w = 0; w < len; w++) begin
      #1;
      chk_word(p, tag, w, len);
      step();
    end
  endtask

  task automatic chk_idle_regs(string tag, int cnt, int grant);
    #1;
    chk({tag, "_tvalid"}, DW'(m_axis_tvalid), DW'(0));
    chk({tag, "_busy"}, DW'(o_busy), DW'(0));
    chk({tag, "_cnt"}, DW'(o_pkt_cnt), DW'(cnt));
    chk({tag, "_grant"}, DW'(o_grant), DW'(grant));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_axis_tready = 1'b0;
    axis_resetn   = 1'b1;
    refresh();
    #2 axis_resetn = 1'b0;
    @(posedge clk);
    #2;
    chk("rst_tvalid", DW'(m_axis_tvalid), DW'(0));
    chk("rst_rd_en", DW'(fifo_rd_en), DW'(0));
    chk("rst_busy", DW'(o_busy), DW'(0));
    chk("rst_grant", DW'(o_grant), DW'(0));
    chk("rst_cnt", DW'(o_pkt_cnt), DW'(0));
    chk("rst_tdata", m_axis_tdata, DW'(0));
    chk("rst_tlast", DW'(m_axis_tlast), DW'(0));
    step();
    axis_resetn = 1'b1;

    // Round robin from reset: every port holds two 2-word packets.
    for (int p = 0; p < N; p++) begin
      push_words(p, 0, 0, 1, 2);
      push_words(p, 1, 0, 1, 2);
    end
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < N; p++) expect_pkt(p, r, 2);
    chk_idle_regs("rr_end", 8, 3);
    step();

    // Single 3-word packet on port 2.
    push_words(2, 2, 0, 2, 3);
    expect_pkt(2, 2, 3);
    chk_idle_regs("single_end", 9, 2);
    step();

    // Backpressure on SEND cycles 2 and 3 of a 4-word packet on port 3.
    push_words(3, 3, 0, 3, 4);
    m_axis_tready = 1'b1;
    #1 chk("bp_bubble", DW'(m_axis_tvalid), DW'(0));
    step();
    #1 chk_word(3, 3, 0, 4);
    step();
    m_axis_tready = 1'b0;
    #1 chk_word(3, 3, 1, 4);
    step();
    #1 chk_word(3, 3, 1, 4);
    step();
    m_axis_tready = 1'b1;
    for (int w = 1; w < 4; w++) begin
      #1 chk_word(3, 3, w, 4);
      step();
    end
    chk_idle_regs("bp_end", 10, 3);
    step();

    // Port 1 underflows after word 2 of 5 while port 0 waits.
    push_words(1, 4, 0, 1, 5);
    #1 chk("uf_bubble", DW'(m_axis_tvalid), DW'(0));
    step();
    #1 chk_word(1, 4, 0, 5);
    step();
    push_words(0, 7, 0, 1, 2);
    #1 chk_word(1, 4, 1, 5);
    step();
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("uf_tvalid", DW'(m_axis_tvalid), DW'(0));
      chk("uf_busy", DW'(o_busy), DW'(1));
      chk("uf_grant", DW'(o_grant), DW'(1));
      chk("uf_rd_en", DW'(fifo_rd_en), DW'(0));
      step();
    end
    push_words(1, 4, 2, 4, 5);
    for (int w = 2; w < 5; w++) begin
      #1 chk_word(1, 4, w, 5);
      step();
    end
    expect_pkt(0, 7, 2);
    chk_idle_regs("uf_end", 12, 0);
    step();

    // Reset during word 2 of a 4-word packet on port 2.
    push_words(2, 5, 0, 3, 4);
    #1 chk("mr_bubble", DW'(m_axis_tvalid), DW'(0));
    step();
    #1 chk_word(2, 5, 0, 4);
    step();
    #1 chk_word(2, 5, 1, 4);
    axis_resetn = 1'b0;
    #1;
    chk("mr_tvalid", DW'(m_axis_tvalid), DW'(0));
    chk("mr_rd_en", DW'(fifo_rd_en), DW'(0));
    chk("mr_busy", DW'(o_busy), DW'(0));
    chk("mr_cnt", DW'(o_pkt_cnt), DW'(0));
    chk("mr_grant", DW'(o_grant), DW'(0));
    chk("mr_tdata", m_axis_tdata, DW'(0));
    chk("mr_fifo_kept", DW'(q[2].size()), DW'(3));
    q[2].delete();
    refresh();
    step();
    axis_resetn = 1'b1;
    push_words(2, 8, 0, 0, 1);
    push_words(0, 6, 0, 0, 1);
    expect_pkt(0, 6, 1);
    expect_pkt(2, 8, 1);
    chk_idle_regs("mr_end", 2, 2);

    // Counter wrap.
    force dut.pkt_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.pkt_cnt_q;
    #1 chk("wrap_pre", DW'(o_pkt_cnt), DW'(32'hFFFF_FFFF));
    step();
    push_words(1, 9, 0, 0, 1);
    expect_pkt(1, 9, 1);
    chk_idle_regs("wrap_end", 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
